// File: rtl/midori64_dec_core.sv
// midori64_dec_core: iterative Midori64-64 decryption core.
// Accepts ct/key on a valid/ready handshake, runs one inverse round per clock
// (15 rounds), then holds the plaintext until the downstream handshake completes.
// Cell c of a 64-bit word occupies bits [63-4c -: 4]; cells are column-major.
`timescale 1ns/1ps
module midori64_dec_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  pt,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t        fsm;
    fsm_t        fsm_next;
    logic [63:0] st;
    logic [63:0] k0;
    logic [63:0] k1;
    logic [63:0] wk;
    logic [63:0] rk;
    logic [63:0] round_out;
    logic [3:0]  rnd;
    logic        accept;

    // Sb0 S-box; it is an involution, so encryption and decryption share it.
    function automatic logic [3:0] sb0(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;
            4'h1: return 4'hA;
            4'h2: return 4'hD;
            4'h3: return 4'h3;
            4'h4: return 4'hE;
            4'h5: return 4'hB;
            4'h6: return 4'hF;
            4'h7: return 4'h7;
            4'h8: return 4'h8;
            4'h9: return 4'h9;
            4'hA: return 4'h1;
            4'hB: return 4'h5;
            4'hC: return 4'h0;
            4'hD: return 4'h2;
            4'hE: return 4'h4;
            default: return 4'h6;
        endcase
    endfunction

    function automatic logic [63:0] sub_cell(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[4*i +: 4] = sb0(x[4*i +: 4]);
        end
        return r;
    endfunction

    // Each output cell is the XOR of the other three cells of its column.
    function automatic logic [63:0] mix_column(input logic [63:0] x);
        logic [63:0] r;
        logic [3:0]  a, b, c, d;
        r = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            a = x[63 - 16*j -: 4];
            b = x[59 - 16*j -: 4];
            c = x[55 - 16*j -: 4];
            d = x[51 - 16*j -: 4];
            r[63 - 16*j -: 4] = b ^ c ^ d;
            r[59 - 16*j -: 4] = a ^ c ^ d;
            r[55 - 16*j -: 4] = a ^ b ^ d;
            r[51 - 16*j -: 4] = a ^ b ^ c;
        end
        return r;
    endfunction

    // Inverse of ShuffleCells: new cell i = old cell {0,7,14,9,5,2,11,12,15,8,1,6,10,13,4,3}[i].
    function automatic logic [63:0] inv_shuffle(input logic [63:0] x);
        return {x[63:60], x[35:32], x[7:4],   x[27:24],
                x[43:40], x[55:52], x[19:16], x[15:12],
                x[3:0],   x[31:28], x[59:56], x[39:36],
                x[23:20], x[11:8],  x[47:44], x[51:48]};
    endfunction

    // Round constants alpha_0..alpha_14, one bit per cell, cell 0 in bit 15.
    function automatic logic [15:0] alpha(input logic [3:0] r);
        case (r)
            4'd0:    return 16'h15B3;
            4'd1:    return 16'h78C0;
            4'd2:    return 16'hA435;
            4'd3:    return 16'h6213;
            4'd4:    return 16'h104F;
            4'd5:    return 16'hD170;
            4'd6:    return 16'h0266;
            4'd7:    return 16'h0BCC;
            4'd8:    return 16'h9481;
            4'd9:    return 16'h40B8;
            4'd10:   return 16'h7197;
            4'd11:   return 16'h228E;
            4'd12:   return 16'h5130;
            4'd13:   return 16'hF8CA;
            4'd14:   return 16'hDF90;
            default: return 16'h0000;
        endcase
    endfunction

    // Spread each constant bit into the LSB of its cell.
    function automatic logic [63:0] expand_alpha(input logic [15:0] a);
        logic [63:0] r;
        r = '0;
        for (int unsigned c = 0; c < 16; c++) begin
            r[60 - 4*c] = a[15 - c];
        end
        return r;
    endfunction

    assign wk        = k0 ^ k1;
    assign rk        = (rnd[0] ? k1 : k0) ^ expand_alpha(alpha(rnd));
    assign round_out = sub_cell(inv_shuffle(mix_column(st ^ rk)));

    assign in_ready  = rst_n && (fsm == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == RUN);

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state decode: accept in IDLE, finish after round 0, release on out_ready.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (accept)         fsm_next = RUN;
            RUN:     if (rnd == 4'd0)    fsm_next = DONE;
            DONE:    if (out_ready)      fsm_next = IDLE;
            default:                     fsm_next = IDLE;
        endcase
    end

    // Key capture on accept, one inverse round per RUN cycle, plaintext register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= '0;
            k0  <= '0;
            k1  <= '0;
            rnd <= '0;
            pt  <= '0;
        end else if (accept) begin
            k0  <= key[127:64];
            k1  <= key[63:0];
            st  <= sub_cell(ct ^ key[127:64] ^ key[63:0]);
            rnd <= 4'd14;
        end else if (fsm == RUN) begin
            st <= round_out;
            if (rnd != 4'd0) begin
                rnd <= rnd - 4'd1;
            end else begin
                pt <= round_out ^ wk;
            end
        end
    end

endmodule

// File: tb/tb_midori64_dec_core.sv
// tb_midori64_dec_core: directed and randomized checks of the Midori64 decryption core.
`timescale 1ns/1ps
module tb_midori64_dec_core;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  ct;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  pt;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [63:0]  KAT1_CT  = 64'h3c9cceda2bbd449a;
    localparam logic [63:0]  KAT2_CT  = 64'h66bcdc6270d901cd;
    localparam logic [127:0] KAT2_KEY = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
    localparam logic [63:0]  KAT2_PT  = 64'h42c20fd3b586879e;

    localparam int PERM [16] = '{0, 10, 5, 15, 14, 4, 11, 1, 9, 3, 12, 6, 7, 13, 2, 8};
    localparam logic [3:0] SB [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                                       4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};
    localparam logic [15:0] ALPHA [15] = '{16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F,
                                           16'hD170, 16'h0266, 16'h0BCC, 16'h9481, 16'h40B8,
                                           16'h7197, 16'h228E, 16'h5130, 16'hF8CA, 16'hDF90};

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    midori64_dec_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .busy      (busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_sub(input logic [63:0] x);
        logic [63:0] y;
        for (int c = 0; c < 16; c++) y[63-4*c -: 4] = SB[x[63-4*c -: 4]];
        return y;
    endfunction

    function automatic logic [63:0] m_shuf(input logic [63:0] x);
        logic [63:0] y;
        for (int c = 0; c < 16; c++) y[63-4*c -: 4] = x[63-4*PERM[c] -: 4];
        return y;
    endfunction

    function automatic logic [63:0] m_ishuf(input logic [63:0] x);
        logic [63:0] y;
        for (int c = 0; c < 16; c++) y[63-4*PERM[c] -: 4] = x[63-4*c -: 4];
        return y;
    endfunction

    function automatic logic [63:0] m_mix(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  tot;
        for (int j = 0; j < 4; j++) begin
            tot = '0;
            for (int i = 0; i < 4; i++) tot = tot ^ x[63-16*j-4*i -: 4];
            for (int i = 0; i < 4; i++) y[63-16*j-4*i -: 4] = tot ^ x[63-16*j-4*i -: 4];
        end
        return y;
    endfunction

    function automatic logic [63:0] m_rk(input logic [127:0] k, input int r);
        logic [63:0] v;
        logic [15:0] a;
        v = (r % 2 == 0) ? k[127:64] : k[63:0];
        a = ALPHA[r];
        for (int c = 0; c < 16; c++) v[60-4*c] = v[60-4*c] ^ a[15-c];
        return v;
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] p, input logic [127:0] k);
        logic [63:0] s;
        logic [63:0] w;
        w = k[127:64] ^ k[63:0];
        s = p ^ w;
        for (int r = 0; r < 15; r++) s = m_mix(m_shuf(m_sub(s))) ^ m_rk(k, r);
        return m_sub(s) ^ w;
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] c, input logic [127:0] k);
        logic [63:0] s;
        logic [63:0] w;
        w = k[127:64] ^ k[63:0];
        s = m_sub(c ^ w);
        for (int r = 14; r >= 0; r--) s = m_sub(m_ishuf(m_mix(s ^ m_rk(k, r))));
        return s ^ w;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        ok = (out_valid === 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ct = '0; key = '0;
        step();
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (pt !== 64'h0) begin n_fail++; $display("FAIL reset_pt: got %h want 0", pt); end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_kat1(input string tag);
        int early = 0;
        ct = KAT1_CT; key = '0; out_ready = 1'b1; in_valid = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b want 1", tag, in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL %s_busy: busy=%b in_ready=%b want 1/0", tag, busy, in_ready); end
        for (int k = 1; k < 15; k++) begin
            step();
            if (out_valid !== 1'b0) early++;
        end
        step();
        n_checks++;
        if (early != 0) begin n_fail++; $display("FAIL %s_early_valid: %0d cycles want 0", tag, early); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency: out_valid=%b want 1 at edge 15", tag, out_valid); end
        n_checks++;
        if (pt !== 64'h0) begin n_fail++; $display("FAIL %s_pt: got %h want 0000000000000000", tag, pt); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_done: got %b want 0", tag, busy); end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL %s_single_pulse: out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        ct = KAT2_CT; key = KAT2_KEY; out_ready = 1'b0; in_valid = 1'b1;
        step();
        ct = '0; key = '0;
        for (int k = 1; k <= 15; k++) step();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL kat2_latency: out_valid=%b want 1", out_valid); end
        n_checks++;
        if (pt !== KAT2_PT) begin n_fail++; $display("FAIL kat2_pt: got %h want %h", pt, KAT2_PT); end
        for (int k = 0; k < 10; k++) begin
            step();
            if (pt !== KAT2_PT || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL hold: %0d unstable cycles want 0", bad); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        ct = KAT2_CT; key = KAT2_KEY; out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL abort_ctrl: out_valid=%b busy=%b in_ready=%b want 0/0/0", out_valid, busy, in_ready); end
        n_checks++;
        if (pt !== 64'h0) begin n_fail++; $display("FAIL abort_pt: got %h want 0", pt); end
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL abort_hold: out_valid=%b busy=%b want 0/0", out_valid, busy); end
        rst_n = 1'b1;
        step();
        test_kat1("post_reset");
    endtask

    task automatic test_isolation();
        logic [63:0] exp_q [$];
        int          acc_cyc [$];
        int          results = 0;
        bit          ok;
        out_ready = 1'b1; in_valid = 1'b1; ct = KAT1_CT; key = '0;
        exp_q.push_back(64'h0);
        acc_cyc.push_back(cyc);
        step();
        for (int k = 0; k < 40; k++) begin
            ct  = {$urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            if (in_ready === 1'b1) begin
                exp_q.push_back(m_dec(ct, key));
                acc_cyc.push_back(cyc);
            end
            if (out_valid === 1'b1) begin
                results++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL iso_extra: pt=%h with nothing outstanding", pt);
                end else begin
                    if (pt !== exp_q[0]) begin n_fail++; $display("FAIL iso_pt%0d: got %h want %h", results, pt, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (results != 2) begin n_fail++; $display("FAIL iso_results: got %0d want 2", results); end
        n_checks++;
        if (acc_cyc.size() != 3) begin n_fail++; $display("FAIL iso_accepts: got %0d want 3", acc_cyc.size()); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != 17)
                begin n_fail++; $display("FAIL iso_period%0d: got %0d want 17", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
        wait_valid(40, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL iso_drain_timeout: out_valid=%b want 1", out_valid);
        end else if (exp_q.size() == 0 || pt !== exp_q[0]) begin
            n_fail++; $display("FAIL iso_drain_pt: got %h want %h", pt, (exp_q.size() != 0) ? exp_q[0] : 64'h0);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0]  exp_q [$];
        logic [63:0]  cur_pt = '0;
        logic [63:0]  p;
        logic [127:0] k;
        int sent = 0, got = 0, spurious = 0, budget = 0;
        bit pending = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        while (got < 1000 && budget < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    spurious++;
                end else begin
                    n_checks++;
                    if (pt !== exp_q[0]) begin n_fail++; $display("FAIL b2b_pt%0d: got %h want %h", got, pt, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (!pending) in_valid = 1'b0;
            if (!pending && sent < 1000 && $urandom_range(0, 2) != 0) begin
                p   = {$urandom, $urandom};
                k   = {$urandom, $urandom, $urandom, $urandom};
                ct  = m_enc(p, k);
                key = k;
                cur_pt   = p;
                pending  = 1'b1;
                in_valid = 1'b1;
            end
            if (pending && in_ready === 1'b1) begin
                exp_q.push_back(cur_pt);
                sent++;
                pending = 1'b0;
            end
            step();
            budget++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got != 1000) begin n_fail++; $display("FAIL b2b_count: got %0d results want 1000", got); end
        n_checks++;
        if (sent != 1000) begin n_fail++; $display("FAIL b2b_sent: got %0d accepts want 1000", sent); end
        n_checks++;
        if (spurious != 0) begin n_fail++; $display("FAIL b2b_spurious: got %0d want 0", spurious); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_dropped: %0d outstanding want 0", exp_q.size()); end
        step();
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_kat1("kat1");
        test_backpressure();
        test_reset_mid();
        test_isolation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached after %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/midori64_dec_core.md
# midori64_dec_core

Iterative Midori64 decryption core: accepts a 64-bit ciphertext and a 128-bit key through a valid/ready handshake. It runs one inverse round per clock and returns the 64-bit plaintext through a second valid/ready handshake. It is the receive-side counterpart of the team's Midori64 encryption datapath. It shares that datapath's SubCell S-box (Sb0), MixColumn, round-constant table and cell ordering, and uses InvShuffleCells in place of ShuffleCells.

## Interface
- Parameters: none. The block is fixed at a 64-bit block, a 128-bit key and 15 inner rounds.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ct/key valid
- in_ready  out  1  core can accept; high only in IDLE and while rst_n is high
- ct  in  64  ciphertext; leftmost hex digit maps to bits [63:60]
- key  in  128  K0 = key[127:64], K1 = key[63:0]
- out_valid  out  1  pt valid
- out_ready  in  1  downstream accepts pt
- pt  out  64  plaintext, same bit convention as ct
- busy  out  1  high in RUN

## Operation
- Derived values:
  - WK = K0 ^ K1.
  - RK_i = (i even ? K0 : K1) ^ alpha_i, for i = 0..14.
  - Each alpha_i bit is XORed into the LSB of its cell, using the shared Midori64 constant table.
- Decryption sequence (exact inverse of encryption):
  - s = SubCell(ct ^ WK).
  - For i = 14 down to 0: s = SubCell(InvShuffleCells(MixColumn(s ^ RK_i))).
  - pt = s ^ WK.
- SubCell and MixColumn are involutions and are reused unchanged from the encryption datapath.
- State machine:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - latch K0 and K1;
    - state <= SubCell(ct ^ WK);
    - rnd <= 14;
    - go to RUN.
  - RUN: each cycle, state <= SubCell(InvShuffleCells(MixColumn(state ^ RK_rnd))).
    - If rnd != 0: rnd <= rnd - 1.
    - If rnd == 0: pt <= result ^ WK, go to DONE.
  - DONE: out_valid = 1 and pt holds stable. On out_valid & out_ready, go to IDLE.
- Width rules:
  - rnd is 4 bits and never wraps; it is not decremented past 0.
  - The key registers hold 128 bits; WK is recomputed combinationally from them.
- ct and key are sampled only on the accept edge. Changes to them in RUN or DONE are ignored.
- in_valid asserted in RUN or DONE has no effect; in_ready stays 0 in those states.
- DONE never accepts a new block in the same cycle it releases pt. The core first returns to IDLE, and in_ready rises the following cycle.

## Timing
- Reset (async assert, sync release) values:
  - state = IDLE, rnd = 0;
  - in_ready = 0 while rst_n is low, 1 after release;
  - out_valid = 0, busy = 0;
  - pt = 64'h0;
  - internal state and key registers = 0.
- Latency:
  - Edge 0: accept.
  - Edges 1..15: 15 RUN cycles.
  - out_valid is high after edge 15, i.e. 15 cycles after the accept edge.
- Minimum block period: 17 cycles (accept, 15 RUN cycles, 1 DONE cycle, then back to IDLE).
- out_valid and pt are registered. pt must not change while out_valid = 1 and out_ready = 0.
- rst_n asserted in RUN or DONE: abort immediately and return to reset values. No out_valid pulse and no partial pt is ever exposed.
- busy is registered-state-derived: it rises with the edge after accept and falls with the edge that enters DONE.

## Test plan
- KAT 1: key = 0, ct = 64'h3c9cceda2bbd449a, out_ready = 1 -> pt = 64'h0000000000000000, out_valid high exactly 15 cycles after the accept edge, then a single-cycle out_valid.
- KAT 2: key = 128'h687ded3b3c85b3f35b1009863e2a8cbf, ct = 64'h66bcdc6270d901cd -> pt = 64'h42c20fd3b586879e.
- Back-pressure: KAT 2 with out_ready = 0 for 10 cycles after out_valid -> pt stays 64'h42c20fd3b586879e, out_valid stays 1, in_ready stays 0. Release out_ready -> IDLE next cycle, in_ready = 1.
- Input isolation: in_valid held at 1 continuously. ct and key change to random values every cycle after accepting KAT 1 -> pt = 0 from KAT 1. Exactly one accept per 17 cycles. Second result matches a reference model of the values present on the second accept edge.
- Reset mid-operation: assert rst_n low in the 7th RUN cycle of KAT 2 -> out_valid = 0, busy = 0, pt = 0 immediately. After release, a fresh KAT 1 completes correctly with 15-cycle latency.
- Back-to-back: 1000 random key/pt pairs encrypted by a model, decrypted through the core with random in_valid/out_ready gaps -> every pt matches, in order, with no drops or duplicates.
